// File: rtl/gpu_vga_timing_gen.sv
// Parametrised VGA raster timing generator: sync, display enable, coordinates and line/frame markers.
// Optional coordinate lookahead ports are built when GPU_VGA_LOOKAHEAD_EN is defined.
module gpu_vga_timing_gen #(
   parameter int H_DISPLAY = 640,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int H_FP      = 16,
   parameter int V_DISPLAY = 480,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int V_FP      = 10,
   parameter int HSYNC_POL = 0,
   parameter int VSYNC_POL = 0,
   parameter int CNT_W     = 11,
   parameter int LOOKAHEAD = 2
) (
   input  logic             clockVGA,
   input  logic             reset,
   input  logic             pixelEnable,
   output logic             hsync,
   output logic             vsync,
   output logic             displayEnable,
   output logic [CNT_W-1:0] col,
   output logic [CNT_W-1:0] row,
   output logic             lineStart,
   output logic             frameStart,
   output logic             vblank
`ifdef GPU_VGA_LOOKAHEAD_EN
   ,
   output logic             preDisplayEnable,
   output logic [CNT_W-1:0] preCol,
   output logic [CNT_W-1:0] preRow
`endif
);

   localparam int H_TOTAL = H_SYNC + H_BP + H_DISPLAY + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_DISPLAY + V_FP;

   localparam logic [CNT_W-1:0] ZERO_C   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
   localparam logic [CNT_W-1:0] H_LAST_C = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST_C = CNT_W'(V_TOTAL - 1);

   // One extra bit so a display end equal to the total still compares correctly.
   localparam logic [CNT_W:0] H_SYNC_C  = (CNT_W+1)'(H_SYNC);
   localparam logic [CNT_W:0] H_START_C = (CNT_W+1)'(H_SYNC + H_BP);
   localparam logic [CNT_W:0] H_END_C   = (CNT_W+1)'(H_SYNC + H_BP + H_DISPLAY);
   localparam logic [CNT_W:0] V_SYNC_C  = (CNT_W+1)'(V_SYNC);
   localparam logic [CNT_W:0] V_START_C = (CNT_W+1)'(V_SYNC + V_BP);
   localparam logic [CNT_W:0] V_END_C   = (CNT_W+1)'(V_SYNC + V_BP + V_DISPLAY);

   localparam logic HS_ACT_C = (HSYNC_POL != 32'sd0);
   localparam logic VS_ACT_C = (VSYNC_POL != 32'sd0);

   typedef struct packed {
      logic             hsync;
      logic             vsync;
      logic             displayEnable;
      logic [CNT_W-1:0] col;
      logic [CNT_W-1:0] row;
      logic             lineStart;
      logic             frameStart;
      logic             vblank;
   } timing_t;

   function automatic logic [CNT_W-1:0] stepH(input logic [CNT_W-1:0] h);
      logic [CNT_W-1:0] r;
      if (h == H_LAST_C) r = ZERO_C;
      else r = h + ONE_C;
      return r;
   endfunction

   function automatic logic [CNT_W-1:0] stepV(input logic [CNT_W-1:0] h, input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      if (h != H_LAST_C) r = v;
      else if (v == V_LAST_C) r = ZERO_C;
      else r = v + ONE_C;
      return r;
   endfunction

   function automatic logic inH(input logic [CNT_W-1:0] h);
      return ({1'b0, h} >= H_START_C) && ({1'b0, h} < H_END_C);
   endfunction

   function automatic logic inV(input logic [CNT_W-1:0] v);
      return ({1'b0, v} >= V_START_C) && ({1'b0, v} < V_END_C);
   endfunction

   // Subtraction only happens inside the visible window, so it cannot wrap.
   function automatic logic [CNT_W-1:0] colAt(input logic [CNT_W-1:0] h);
      return inH(h) ? (h - H_START_C[CNT_W-1:0]) : ZERO_C;
   endfunction

   function automatic logic [CNT_W-1:0] rowAt(input logic [CNT_W-1:0] v);
      return inV(v) ? (v - V_START_C[CNT_W-1:0]) : ZERO_C;
   endfunction

   function automatic timing_t decodeAt(input logic [CNT_W-1:0] h, input logic [CNT_W-1:0] v);
      timing_t d;
      d.hsync         = ({1'b0, h} < H_SYNC_C) ? HS_ACT_C : ~HS_ACT_C;
      d.vsync         = ({1'b0, v} < V_SYNC_C) ? VS_ACT_C : ~VS_ACT_C;
      d.displayEnable = inH(h) & inV(v);
      d.col           = colAt(h);
      d.row           = rowAt(v);
      d.lineStart     = (h == ZERO_C);
      d.frameStart    = (h == ZERO_C) && (v == ZERO_C);
      d.vblank        = ~inV(v);
      return d;
   endfunction

   function automatic timing_t resetTiming();
      timing_t d;
      d.hsync         = ~HS_ACT_C;
      d.vsync         = ~VS_ACT_C;
      d.displayEnable = 1'b0;
      d.col           = ZERO_C;
      d.row           = ZERO_C;
      d.lineStart     = 1'b0;
      d.frameStart    = 1'b0;
      d.vblank        = 1'b1;
      return d;
   endfunction

   logic [CNT_W-1:0] hCnt_r;
   logic [CNT_W-1:0] vCnt_r;
   timing_t          timing_r;

   // Raster counters and registered decode of the pre-increment position.
   always_ff @(posedge clockVGA) begin
      if (reset) begin
         hCnt_r   <= ZERO_C;
         vCnt_r   <= ZERO_C;
         timing_r <= resetTiming();
      end else if (pixelEnable) begin
         hCnt_r   <= stepH(hCnt_r);
         vCnt_r   <= stepV(hCnt_r, vCnt_r);
         timing_r <= decodeAt(hCnt_r, vCnt_r);
      end else begin
         hCnt_r   <= hCnt_r;
         vCnt_r   <= vCnt_r;
         timing_r <= timing_r;
      end
   end

   assign hsync         = timing_r.hsync;
   assign vsync         = timing_r.vsync;
   assign displayEnable = timing_r.displayEnable;
   assign col           = timing_r.col;
   assign row           = timing_r.row;
   assign lineStart     = timing_r.lineStart;
   assign frameStart    = timing_r.frameStart;
   assign vblank        = timing_r.vblank;

`ifdef GPU_VGA_LOOKAHEAD_EN
   localparam logic [CNT_W-1:0] LA_H_C = CNT_W'(LOOKAHEAD % H_TOTAL);
   localparam logic [CNT_W-1:0] LA_V_C = CNT_W'((LOOKAHEAD / H_TOTAL) % V_TOTAL);

   logic [CNT_W-1:0] laH_r;
   logic [CNT_W-1:0] laV_r;
   logic             preDe_r;
   logic [CNT_W-1:0] preCol_r;
   logic [CNT_W-1:0] preRow_r;

   // Shadow counter pair running LOOKAHEAD pixels ahead of the main raster.
   always_ff @(posedge clockVGA) begin
      if (reset) begin
         laH_r    <= LA_H_C;
         laV_r    <= LA_V_C;
         preDe_r  <= 1'b0;
         preCol_r <= ZERO_C;
         preRow_r <= ZERO_C;
      end else if (pixelEnable) begin
         laH_r    <= stepH(laH_r);
         laV_r    <= stepV(laH_r, laV_r);
         preDe_r  <= inH(laH_r) & inV(laV_r);
         preCol_r <= colAt(laH_r);
         preRow_r <= rowAt(laV_r);
      end else begin
         laH_r    <= laH_r;
         laV_r    <= laV_r;
         preDe_r  <= preDe_r;
         preCol_r <= preCol_r;
         preRow_r <= preRow_r;
      end
   end

   assign preDisplayEnable = preDe_r;
   assign preCol           = preCol_r;
   assign preRow           = preRow_r;
`else
   logic unusedLookahead_s;
   assign unusedLookahead_s = (LOOKAHEAD != 32'sd0);
`endif

endmodule

// File: tb/tb_gpu_vga_timing_gen.sv
// Scoreboard bench for gpu_vga_timing_gen on a small raster; expected outputs come from a
// frame-position model (pixel index -> h/v via div/mod), checked by an independent monitor.
module tb_gpu_vga_timing_gen;
   localparam int HD = 8, HS = 3, HB = 2, HF = 2;
   localparam int VD = 5, VS = 2, VB = 2, VF = 1;
   localparam int HP = 1, VP = 0, CW = 6, LA = 17;
   localparam int HT = HD + HS + HB + HF;
   localparam int VT = VD + VS + VB + VF;
   localparam int FT = HT * VT;

   logic          clockVGA = 1'b0;
   logic          reset = 1'b1;
   logic          pixelEnable = 1'b0;
   logic          hsync, vsync, displayEnable, lineStart, frameStart, vblank;
   logic [CW-1:0] col, row;
`ifdef GPU_VGA_LOOKAHEAD_EN
   logic          preDisplayEnable;
   logic [CW-1:0] preCol, preRow;
`endif

   gpu_vga_timing_gen #(
      .H_DISPLAY(HD), .H_SYNC(HS), .H_BP(HB), .H_FP(HF),
      .V_DISPLAY(VD), .V_SYNC(VS), .V_BP(VB), .V_FP(VF),
      .HSYNC_POL(HP), .VSYNC_POL(VP), .CNT_W(CW), .LOOKAHEAD(LA)
   ) dut (
      .clockVGA(clockVGA), .reset(reset), .pixelEnable(pixelEnable),
      .hsync(hsync), .vsync(vsync), .displayEnable(displayEnable),
      .col(col), .row(row), .lineStart(lineStart), .frameStart(frameStart),
      .vblank(vblank)
`ifdef GPU_VGA_LOOKAHEAD_EN
      , .preDisplayEnable(preDisplayEnable), .preCol(preCol), .preRow(preRow)
`endif
   );

   always #5 clockVGA = ~clockVGA;

   typedef struct {
      logic hs, vs, de, ls, fs, vb, pde;
      int   c, r, pc, pr;
   } exp_t;

   exp_t q[$];
   exp_t held;
   int   pos = 0;
   int   passCnt = 0;
   int   checkCnt = 0;
   int   maxCol = -1;
   int   maxRow = -1;
   int   deCount = 0;
   int   expDeCount = 0;

   // Visible-region view of a frame position: enable plus coordinates.
   function automatic void dispAt(input int p, output logic de, output int c, output int r);
      int h, v;
      logic hd, vd;
      h  = p % HT;
      v  = p / HT;
      hd = (h >= HS + HB) && (h < HS + HB + HD);
      vd = (v >= VS + VB) && (v < VS + VB + VD);
      de = hd && vd;
      c  = hd ? h - (HS + HB) : 0;
      r  = vd ? v - (VS + VB) : 0;
   endfunction

   function automatic exp_t expAt(input int p);
      exp_t e;
      int h, v;
      h    = p % HT;
      v    = p / HT;
      e.hs = (h < HS) ? (HP != 0) : (HP == 0);
      e.vs = (v < VS) ? (VP != 0) : (VP == 0);
      dispAt(p, e.de, e.c, e.r);
      e.ls = (h == 0);
      e.fs = (p == 0);
      e.vb = !((v >= VS + VB) && (v < VS + VB + VD));
      dispAt((p + LA) % FT, e.pde, e.pc, e.pr);
      return e;
   endfunction

   function automatic exp_t resetExp();
      exp_t e;
      e.hs = (HP == 0); e.vs = (VP == 0);
      e.de = 1'b0; e.c = 0; e.r = 0;
      e.ls = 1'b0; e.fs = 1'b0; e.vb = 1'b1;
      e.pde = 1'b0; e.pc = 0; e.pr = 0;
      return e;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checkCnt++;
      if (act == exp) passCnt++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Drive one clock of stimulus and queue the response the model predicts for it.
   task automatic step(input logic rst, input logic pe);
      reset       = rst;
      pixelEnable = pe;
      if (rst) begin
         held = resetExp();
         pos  = 0;
      end else if (pe) begin
         held = expAt(pos);
         pos  = (pos + 1) % FT;
      end
      if (held.de) expDeCount++;
      q.push_back(held);
      @(posedge clockVGA);
      #1;
   endtask

   // Monitor: pop one expectation per clock and compare away from the active edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clockVGA);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("hsync", int'(hsync), int'(e.hs));
            chk("vsync", int'(vsync), int'(e.vs));
            chk("displayEnable", int'(displayEnable), int'(e.de));
            chk("col", int'(col), e.c);
            chk("row", int'(row), e.r);
            chk("lineStart", int'(lineStart), int'(e.ls));
            chk("frameStart", int'(frameStart), int'(e.fs));
            chk("vblank", int'(vblank), int'(e.vb));
`ifdef GPU_VGA_LOOKAHEAD_EN
            chk("preDisplayEnable", int'(preDisplayEnable), int'(e.pde));
            chk("preCol", int'(preCol), e.pc);
            chk("preRow", int'(preRow), e.pr);
`endif
            if (displayEnable) begin
               deCount++;
               if (int'(col) > maxCol) maxCol = int'(col);
               if (int'(row) > maxRow) maxRow = int'(row);
            end
         end
      end
   end

   initial begin
      held = resetExp();
      repeat (4) step(1'b1, 1'b1);
      repeat (2 * FT) step(1'b0, 1'b1);
      for (int i = 0; i < 2 * FT; i++) step(1'b0, (i % 2) == 0);
      for (int k = 0; k < FT && pos != 2 * HT + 5; k++) step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      repeat (FT + 5) step(1'b0, 1'b1);
      step(1'b1, 1'b0);
      for (int i = 0; i < 10 * FT; i++)
         step($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0);
      step(1'b0, 1'b0);
      for (int w = 0; w < 10 && q.size() != 0; w++) @(negedge clockVGA);
      @(posedge clockVGA);
      chk("drain", q.size(), 0);
      chk("maxCol", maxCol, HD - 1);
      chk("maxRow", maxRow, VD - 1);
      chk("displayEnableCount", deCount, expDeCount);
      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end
endmodule
